// File: rtl/fifo_sync_param_pkg.sv
// Common types and defaults for the parametrised synchronous FIFO.
`include "fifo_defs.vh"

package fifo_sync_param_pkg;

    localparam int DEFAULT_DATA_W = `FIFO_DEFAULT_DATA_W;
    localparam int DEFAULT_DEPTH  = `FIFO_DEFAULT_DEPTH;

    // Transfer kind in one cycle, encoded as {read_accepted, write_accepted}.
    typedef enum logic [1:0] {
        XFER_IDLE = 2'b00,
        XFER_PUSH = 2'b01,
        XFER_POP  = 2'b10,
        XFER_BOTH = 2'b11
    } xfer_e;

endpackage

// File: rtl/fifo_defs.vh
// Shared defaults and width helper for the FIFO family.
`ifndef FIFO_DEFS_VH
`define FIFO_DEFS_VH

`define FIFO_DEFAULT_DATA_W 8
`define FIFO_DEFAULT_DEPTH  8

// Bits needed to index n distinct values; never less than one bit.
`define FIFO_CLOG2_W(n) (((n) < 2) ? 1 : $clog2(n))

`endif

// File: rtl/fifo_wrap_ptr.sv
// Wrap-around index counter: counts 0..DEPTH-1 and returns to 0.
// The wrap is an explicit compare, so any DEPTH >= 2 works.
`include "fifo_defs.vh"

module fifo_wrap_ptr
    import fifo_sync_param_pkg::*;
#(
    parameter int  DEPTH = DEFAULT_DEPTH,
    localparam int PTR_W = `FIFO_CLOG2_W(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    // Advance on inc, wrapping from the last entry back to entry 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (inc) begin
            if (ptr == PTR_W'(DEPTH - 1)) begin
                ptr <= '0;
            end else begin
                ptr <= ptr + PTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, full/empty/almost
// flags, sticky overflow/underflow and optional first-word-fall-through.
//
// Handshake: enable_write / enable_read are requests sampled at the rising
// edge. A write is accepted when the FIFO is not full, or when a read is
// accepted in the same cycle (the pop frees the slot the push uses). A read
// is accepted only when the FIFO is not empty; a write landing in the same
// cycle never satisfies it. Rejected requests have no effect on storage and
// raise the matching sticky flag. read_valid qualifies value_to_read: in
// registered mode it pulses for one cycle after each accepted read; in FWFT
// mode it is high whenever a head word is on display.
`include "fifo_defs.vh"

module fifo_sync_param
    import fifo_sync_param_pkg::*;
#(
    parameter int  DATA_W   = DEFAULT_DATA_W,
    parameter int  DEPTH    = DEFAULT_DEPTH,
    parameter int  AF_LEVEL = 6,
    parameter int  AE_LEVEL = 1,
    parameter bit  FWFT     = 1'b0,
    localparam int PTR_W    = `FIFO_CLOG2_W(DEPTH),
    localparam int CNT_W    = `FIFO_CLOG2_W(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable_write,
    input  logic [DATA_W-1:0] value_to_write,
    input  logic              enable_read,
    output logic [DATA_W-1:0] value_to_read,
    output logic              read_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              underflow,
    input  logic              clear_errors
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic              overflow_q;
    logic              underflow_q;

    logic  rd_accept;
    logic  wr_accept;
    logic  wr_reject;
    logic  rd_reject;
    xfer_e xfer;

    // Acceptance decode; flags come from the registered count only.
    assign rd_accept = enable_read && !empty;
    assign wr_accept = enable_write && (!full || rd_accept);
    assign wr_reject = enable_write && !wr_accept;
    assign rd_reject = enable_read && !rd_accept;
    assign xfer      = xfer_e'({rd_accept, wr_accept});

    assign full         = (count_q == CNT_W'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CNT_W'(AF_LEVEL));
    assign almost_empty = (count_q <= CNT_W'(AE_LEVEL));
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    fifo_wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (wr_accept),
        .ptr (wr_ptr)
    );

    fifo_wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (rd_accept),
        .ptr (rd_ptr)
    );

    // Storage write; contents are never reset, the pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= value_to_write;
        end
    end

    // Occupancy: push-only grows, pop-only shrinks, both or neither holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            case (xfer)
                XFER_PUSH: count_q <= count_q + CNT_W'(1);
                XFER_POP:  count_q <= count_q - CNT_W'(1);
                default:   count_q <= count_q;
            endcase
        end
    end

    // Sticky error flags; a new error in the clearing cycle wins over the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= (overflow_q  && !clear_errors) || wr_reject;
            underflow_q <= (underflow_q && !clear_errors) || rd_reject;
        end
    end

    generate
        if (FWFT) begin : g_fwft
            // Head word shown combinationally; zero while nothing is stored.
            always_comb begin
                value_to_read = '0;
                if (!empty) begin
                    value_to_read = mem[rd_ptr];
                end
            end
            assign read_valid = !empty;
        end else begin : g_reg
            logic [DATA_W-1:0] rd_data_q;
            logic              rd_valid_q;

            // Registered read: load the head on an accepted read, hold otherwise.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_accept;
                    if (rd_accept) begin
                        rd_data_q <= mem[rd_ptr];
                    end
                end
            end

            assign value_to_read = rd_data_q;
            assign read_valid    = rd_valid_q;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_sync_param.sv
// Bench for fifo_sync_param: a registered-read instance (DEPTH 8) and an
// FWFT instance (DEPTH 5), both compared against queue-based models.
module tb_fifo_sync_param;

    localparam int DEPTH_A = 8;
    localparam int AF_A    = 6;
    localparam int AE_A    = 1;
    localparam int DEPTH_B = 5;
    localparam int AF_B    = 4;
    localparam int AE_B    = 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    always #5 clk = ~clk;

    // ---------------- instance A: FWFT=0, DEPTH=8 ----------------
    logic       we_a = 1'b0, re_a = 1'b0, clr_a = 1'b0;
    logic [7:0] d_a = '0;
    logic [7:0] q_a;
    logic       rv_a, full_a, empty_a, af_a, ae_a, ov_a, un_a;
    logic [3:0] cnt_a;

    fifo_sync_param #(
        .DATA_W(8), .DEPTH(DEPTH_A), .AF_LEVEL(AF_A), .AE_LEVEL(AE_A), .FWFT(1'b0)
    ) u_dut_a (
        .clk            (clk),
        .rst            (rst_a),
        .enable_write   (we_a),
        .value_to_write (d_a),
        .enable_read    (re_a),
        .value_to_read  (q_a),
        .read_valid     (rv_a),
        .full           (full_a),
        .empty          (empty_a),
        .almost_full    (af_a),
        .almost_empty   (ae_a),
        .count          (cnt_a),
        .overflow       (ov_a),
        .underflow      (un_a),
        .clear_errors   (clr_a)
    );

    // ---------------- instance B: FWFT=1, DEPTH=5 ----------------
    logic       we_b = 1'b0, re_b = 1'b0, clr_b = 1'b0;
    logic [7:0] d_b = '0;
    logic [7:0] q_b;
    logic       rv_b, full_b, empty_b, af_b, ae_b, ov_b, un_b;
    logic [2:0] cnt_b;

    fifo_sync_param #(
        .DATA_W(8), .DEPTH(DEPTH_B), .AF_LEVEL(AF_B), .AE_LEVEL(AE_B), .FWFT(1'b1)
    ) u_dut_b (
        .clk            (clk),
        .rst            (rst_b),
        .enable_write   (we_b),
        .value_to_write (d_b),
        .enable_read    (re_b),
        .value_to_read  (q_b),
        .read_valid     (rv_b),
        .full           (full_b),
        .empty          (empty_b),
        .almost_full    (af_b),
        .almost_empty   (ae_b),
        .count          (cnt_b),
        .overflow       (ov_b),
        .underflow      (un_b),
        .clear_errors   (clr_b)
    );

    // ---------------- models and scoreboard ----------------
    logic [7:0] mq_a[$];
    logic [7:0] mq_b[$];
    logic [7:0] exp_q[$];
    bit         m_ov_a = 0, m_un_a = 0, m_ov_b = 0, m_un_b = 0;
    logic [7:0] last_a = '0;
    logic [7:0] mon_exp;
    bit         mon_on = 0;
    int         n_vec = 0;
    int         n_mis = 0;

    function automatic void check(input string name, input int unsigned act,
                                  input int unsigned exp);
        n_vec++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Monitor for instance A: every read_valid pulse pops one expected word;
    // between pulses the output must hold the last delivered word.
    always @(negedge clk) begin
        if (mon_on) begin
            if (rv_a) begin
                if (exp_q.size() == 0) begin
                    check("a_read_valid_unexpected", 1, 0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("a_read_data", q_a, mon_exp);
                    last_a = mon_exp;
                end
            end else begin
                check("a_read_hold", q_a, last_a);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic flags_a();
        int n = mq_a.size();
        check("a_count", cnt_a, n);
        check("a_full", full_a, n == DEPTH_A);
        check("a_empty", empty_a, n == 0);
        check("a_almost_full", af_a, n >= AF_A);
        check("a_almost_empty", ae_a, n <= AE_A);
        check("a_overflow", ov_a, m_ov_a);
        check("a_underflow", un_a, m_un_a);
    endtask

    task automatic step_a(input bit we, input bit re, input logic [7:0] d, input bit clr);
        bit rd_ok, wr_ok;
        @(negedge clk);
        we_a = we; re_a = re; d_a = d; clr_a = clr;
        rd_ok  = re && (mq_a.size() > 0);
        wr_ok  = we && ((mq_a.size() < DEPTH_A) || rd_ok);
        m_ov_a = (m_ov_a && !clr) || (we && !wr_ok);
        m_un_a = (m_un_a && !clr) || (re && !rd_ok);
        if (rd_ok) exp_q.push_back(mq_a.pop_front());
        if (wr_ok) mq_a.push_back(d);
        @(posedge clk);
        #1;
        we_a = 0; re_a = 0; clr_a = 0;
        flags_a();
    endtask

    task automatic flags_b();
        int n = mq_b.size();
        check("b_count", cnt_b, n);
        check("b_full", full_b, n == DEPTH_B);
        check("b_empty", empty_b, n == 0);
        check("b_almost_full", af_b, n >= AF_B);
        check("b_almost_empty", ae_b, n <= AE_B);
        check("b_overflow", ov_b, m_ov_b);
        check("b_underflow", un_b, m_un_b);
        check("b_read_valid", rv_b, n > 0);
        if (n > 0) check("b_head_word", q_b, mq_b[0]);
    endtask

    task automatic step_b(input bit we, input bit re, input logic [7:0] d, input bit clr);
        bit rd_ok, wr_ok;
        @(negedge clk);
        we_b = we; re_b = re; d_b = d; clr_b = clr;
        rd_ok  = re && (mq_b.size() > 0);
        wr_ok  = we && ((mq_b.size() < DEPTH_B) || rd_ok);
        m_ov_b = (m_ov_b && !clr) || (we && !wr_ok);
        m_un_b = (m_un_b && !clr) || (re && !rd_ok);
        if (rd_ok) void'(mq_b.pop_front());
        if (wr_ok) mq_b.push_back(d);
        @(posedge clk);
        #1;
        we_b = 0; re_b = 0; clr_b = 0;
        flags_b();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        n_mis++;
        $display("FAIL watchdog: time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1;
        // Reset state of both instances.
        check("a_rst_count", cnt_a, 0);
        check("a_rst_empty", empty_a, 1);
        check("a_rst_full", full_a, 0);
        check("a_rst_almost_empty", ae_a, 1);
        check("a_rst_almost_full", af_a, 0);
        check("a_rst_value", q_a, 0);
        check("a_rst_read_valid", rv_a, 0);
        check("a_rst_overflow", ov_a, 0);
        check("a_rst_underflow", un_a, 0);
        check("b_rst_value", q_b, 0);
        check("b_rst_read_valid", rv_b, 0);
        check("b_rst_empty", empty_b, 1);

        @(negedge clk);
        rst_a = 0; rst_b = 0; mon_on = 1;

        // Read on empty, then clear the error.
        step_a(0, 1, 8'd0, 0);
        step_a(0, 0, 8'd0, 1);
        // Fill with 7..14, then one overflowing write.
        for (int i = 7; i <= 14; i++) step_a(1, 0, 8'(i), 0);
        step_a(1, 0, 8'd15, 0);
        // Drain in order.
        repeat (8) step_a(0, 1, 8'd0, 0);
        step_a(0, 0, 8'd0, 1);
        // Full plus simultaneous read/write, then drain across the wrap.
        for (int i = 7; i <= 14; i++) step_a(1, 0, 8'(i), 0);
        step_a(1, 1, 8'd18, 0);
        repeat (8) step_a(0, 1, 8'd0, 0);
        // Empty plus simultaneous read/write, then read the stored word.
        step_a(1, 1, 8'd9, 0);
        step_a(0, 1, 8'd0, 0);
        step_a(0, 0, 8'd0, 1);
        // Random traffic.
        repeat (400) begin
            step_a($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
                   8'($urandom_range(0, 255)), $urandom_range(0, 19) == 0);
        end
        repeat (DEPTH_A + 1) step_a(0, 1, 8'd0, 0);
        repeat (2) step_a(0, 0, 8'd0, 1);
        check("a_scoreboard_drained", exp_q.size(), 0);

        // FWFT instance: head word visible with no read issued.
        step_b(1, 0, 8'd3, 0);
        check("b_fwft_first_word", q_b, 3);
        check("b_fwft_first_valid", rv_b, 1);
        step_b(0, 1, 8'd0, 0);
        // Fill and drain twice to cross the non-power-of-two wrap.
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < DEPTH_B + 1; i++) step_b(1, 0, 8'(8'h40 + i + 8 * k), 0);
            step_b(1, 1, 8'(8'h70 + k), 0);
            repeat (DEPTH_B + 1) step_b(0, 1, 8'd0, 0);
            step_b(0, 0, 8'd0, 1);
        end
        repeat (200) begin
            step_b($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
                   8'($urandom_range(0, 255)), $urandom_range(0, 19) == 0);
        end
        // Async reset mid-stream takes effect before the next clock edge.
        step_b(1, 0, 8'd21, 0);
        step_b(1, 0, 8'd22, 0);
        @(negedge clk);
        #2;
        rst_b = 1;
        #1;
        check("b_async_rst_empty", empty_b, 1);
        check("b_async_rst_count", cnt_b, 0);
        check("b_async_rst_read_valid", rv_b, 0);
        check("b_async_rst_value", q_b, 0);
        check("b_async_rst_overflow", ov_b, 0);
        mq_b.delete();
        m_ov_b = 0; m_un_b = 0;
        @(negedge clk);
        rst_b = 0;
        step_b(1, 0, 8'd33, 0);
        step_b(1, 1, 8'd34, 0);
        step_b(0, 1, 8'd0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
